// File: rtl/mips_cpu_test_monitor.sv
// End-of-program monitor for mips_cpu_harvard testbenches: halt detection, v0 check, fault/timeout verdict.
// Optional store counter enabled by defining MONITOR_STORE_COUNT_EN.
module mips_cpu_test_monitor #(
    parameter logic [31:0] HALT_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_address,
    input  logic [31:0] register_v0,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] expected_v0,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  fault_code,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count
);

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_PASS   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_MISALIGN = 3'd1;
    localparam logic [2:0] FC_RDWR     = 3'd2;
    localparam logic [2:0] FC_V0       = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;
    localparam logic [2:0] FC_INACTIVE = 3'd5;

    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [2:0]  state_r, state_s;
    logic [2:0]  code_r, code_s;
    logic [31:0] cyc_r, cyc_s;
    logic [31:0] tmo_r, tmo_s;
    logic [3:0]  settle_r, settle_s;
    logic        done_r, pass_r, fail_r;

    // Next-state, fault classification and counter updates for one enabled edge.
    always_comb begin
        state_s  = state_r;
        code_s   = code_r;
        cyc_s    = cyc_r;
        tmo_s    = tmo_r;
        settle_s = settle_r;
        case (state_r)
            ST_WAIT: begin
                if (active) begin
                    state_s = ST_RUN;
                    cyc_s   = 32'd0;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = ST_FAULT;
                    code_s  = FC_TIMEOUT;
                end else begin
                    // The idle-CPU wait shares the timeout budget with RUN.
                    tmo_s = sat_inc32(tmo_r);
                end
            end
            ST_RUN: begin
                cyc_s = sat_inc32(cyc_r);
                tmo_s = sat_inc32(tmo_r);
                if (instr_address[1:0] != 2'b00) begin
                    state_s = ST_FAULT;
                    code_s  = FC_MISALIGN;
                end else if (data_read && data_write) begin
                    state_s = ST_FAULT;
                    code_s  = FC_RDWR;
                end else if (instr_address == HALT_ADDR) begin
                    state_s  = ST_SETTLE;
                    settle_s = 4'd0;
                end else if (!active) begin
                    state_s = ST_FAULT;
                    code_s  = FC_INACTIVE;
                end else if (tmo_r == TMO_LAST) begin
                    state_s = ST_FAULT;
                    code_s  = FC_TIMEOUT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_SETTLE: begin
                cyc_s = sat_inc32(cyc_r);
                if (settle_r == SETTLE_LAST) begin
                    if (register_v0 == expected_v0) begin
                        state_s = ST_PASS;
                    end else begin
                        state_s = ST_FAULT;
                        code_s  = FC_V0;
                    end
                end else begin
                    settle_s = settle_r + 4'd1;
                end
            end
            ST_PASS: begin
                state_s = ST_PASS;
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s = ST_WAIT;
                code_s  = FC_NONE;
            end
        endcase
    end

    // State and registered verdict outputs; clk_enable low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_WAIT;
            code_r   <= FC_NONE;
            cyc_r    <= 32'd0;
            tmo_r    <= 32'd0;
            settle_r <= 4'd0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            fail_r   <= 1'b0;
        end else if (clk_enable) begin
            state_r  <= state_s;
            code_r   <= code_s;
            cyc_r    <= cyc_s;
            tmo_r    <= tmo_s;
            settle_r <= settle_s;
            done_r   <= (state_s == ST_PASS) || (state_s == ST_FAULT);
            pass_r   <= (state_s == ST_PASS);
            fail_r   <= (state_s == ST_FAULT);
        end
    end

    assign done        = done_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign fault_code  = code_r;
    assign cycle_count = cyc_r;

`ifdef MONITOR_STORE_COUNT_EN
    logic [15:0] store_r;

    // Saturating count of data writes while the program is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_r <= 16'h0000;
        end else if (clk_enable && data_write && (store_r != 16'hFFFF) &&
                     ((state_r == ST_RUN) || (state_r == ST_SETTLE))) begin
            store_r <= store_r + 16'd1;
        end
    end

    assign store_count = store_r;
`else
    assign store_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mips_cpu_test_monitor.sv
// Directed bench for mips_cpu_test_monitor; CPU signals are driven directly (TIMEOUT=50, SETTLE=2).
module tb_mips_cpu_test_monitor;

    logic        clk = 1'b0;
    logic        reset, clk_enable, active, data_read, data_write;
    logic [31:0] instr_address, register_v0, expected_v0;
    logic        done, pass, fail;
    logic [2:0]  fault_code;
    logic [31:0] cycle_count;
    logic [15:0] store_count;

    int vectors = 0;
    int errors  = 0;

`ifdef MONITOR_STORE_COUNT_EN
    localparam logic [15:0] EXP_STORES = 16'd3;
`else
    localparam logic [15:0] EXP_STORES = 16'd0;
`endif

    mips_cpu_test_monitor #(
        .HALT_ADDR      (32'h0000_0000),
        .TIMEOUT_CYCLES (50),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .active        (active),
        .instr_address (instr_address),
        .register_v0   (register_v0),
        .data_read     (data_read),
        .data_write    (data_write),
        .expected_v0   (expected_v0),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .fault_code    (fault_code),
        .cycle_count   (cycle_count),
        .store_count   (store_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic verdict(input string tag, input logic d, input logic p, input logic f,
                           input logic [2:0] c, input logic [31:0] cyc);
        chk({tag, ".done"},  32'(done), 32'(d));
        chk({tag, ".pass"},  32'(pass), 32'(p));
        chk({tag, ".fail"},  32'(fail), 32'(f));
        chk({tag, ".code"},  32'(fault_code), 32'(c));
        chk({tag, ".cycle"}, cycle_count, cyc);
    endtask

    task automatic do_reset();
        reset = 1'b1; active = 1'b0; data_read = 1'b0; data_write = 1'b0;
        instr_address = 32'hBFC0_0000; register_v0 = 32'd0;
        tick();
        reset = 1'b0;
    endtask

    // beq not taken, two addiu v0+=1, jr $0; leaves the monitor in SETTLE with cycle_count 7.
    task automatic run_prog();
        register_v0 = 32'd0;
        active = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            instr_address = 32'hBFC0_0000 + 32'(i * 4);
            if (i == 3) register_v0 = 32'd1;
            if (i == 4) register_v0 = 32'd2;
            tick();
        end
        instr_address = 32'h0000_0000;
        tick();
    endtask

    initial begin
        clk_enable = 1'b1; expected_v0 = 32'd2;
        do_reset();
        verdict("reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        chk("reset.store", 32'(store_count), 32'd0);

        // 1: program passes
        run_prog();
        verdict("p1.halt", 1'b0, 1'b0, 1'b0, 3'd0, 32'd7);
        active = 1'b0;
        tick();
        verdict("p1.settle", 1'b0, 1'b0, 1'b0, 3'd0, 32'd8);
        tick();
        verdict("p1.pass", 1'b1, 1'b1, 1'b0, 3'd0, 32'd9);
        tick(); tick();
        verdict("p1.sticky", 1'b1, 1'b1, 1'b0, 3'd0, 32'd9);

        // 2: v0 mismatch
        do_reset();
        verdict("p2.reset", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        expected_v0 = 32'd3;
        run_prog();
        tick();
        verdict("p2.settle", 1'b0, 1'b0, 1'b0, 3'd0, 32'd8);
        tick();
        verdict("p2.v0", 1'b1, 1'b0, 1'b1, 3'd3, 32'd9);

        // 3: loop forever in RUN -> timeout at cycle 50
        do_reset();
        active = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            instr_address = (i % 2 == 0) ? 32'hBFC0_0000 : 32'hBFC0_0004;
            tick();
        end
        verdict("p3.edge", 1'b0, 1'b0, 1'b0, 3'd0, 32'd49);
        tick();
        verdict("p3.tmo", 1'b1, 1'b0, 1'b1, 3'd4, 32'd50);

        // 3b: CPU never goes active
        do_reset();
        for (int i = 0; i < 49; i++) tick();
        verdict("p3b.edge", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        tick();
        verdict("p3b.tmo", 1'b1, 1'b0, 1'b1, 3'd4, 32'd0);

        // 3c: halt on the timeout edge wins
        do_reset();
        expected_v0 = 32'd2; active = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) tick();
        register_v0 = 32'd2; instr_address = 32'h0000_0000;
        tick();
        verdict("p3c.halt", 1'b0, 1'b0, 1'b0, 3'd0, 32'd50);
        tick(); tick();
        verdict("p3c.pass", 1'b1, 1'b1, 1'b0, 3'd0, 32'd52);

        // 4: read+write same cycle
        do_reset();
        active = 1'b1;
        tick();
        tick();
        data_read = 1'b1; data_write = 1'b1;
        tick();
        data_read = 1'b0; data_write = 1'b0;
        verdict("p4.rdwr", 1'b1, 1'b0, 1'b1, 3'd2, 32'd2);
        tick(); tick(); tick();
        verdict("p4.sticky", 1'b1, 1'b0, 1'b1, 3'd2, 32'd2);

        // 4b: fault beats halt on the same edge
        do_reset();
        active = 1'b1;
        tick();
        instr_address = 32'h0000_0000; data_read = 1'b1; data_write = 1'b1;
        tick();
        data_read = 1'b0; data_write = 1'b0;
        verdict("p4b.prio", 1'b1, 1'b0, 1'b1, 3'd2, 32'd1);

        // misaligned fetch
        do_reset();
        active = 1'b1;
        tick();
        instr_address = 32'hBFC0_0002;
        tick();
        verdict("mis", 1'b1, 1'b0, 1'b1, 3'd1, 32'd1);

        // active dropped early
        do_reset();
        active = 1'b1;
        tick();
        tick();
        active = 1'b0;
        tick();
        verdict("drop", 1'b1, 1'b0, 1'b1, 3'd5, 32'd2);

        // 5: reset during SETTLE, then rerun
        do_reset();
        expected_v0 = 32'd2;
        run_prog();
        do_reset();
        verdict("p5.clr", 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        run_prog();
        tick(); tick();
        verdict("p5.pass", 1'b1, 1'b1, 1'b0, 3'd0, 32'd9);

        // 6: three stores, clk_enable gap mid-run
        do_reset();
        expected_v0 = 32'd0;
        active = 1'b1;
        tick();
        data_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_address = 32'hBFC0_0000 + 32'(i * 4);
            tick();
        end
        data_write = 1'b0; instr_address = 32'hBFC0_000C;
        tick();
        clk_enable = 1'b0; data_write = 1'b1; active = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        verdict("p6.gap", 1'b0, 1'b0, 1'b0, 3'd0, 32'd4);
        chk("p6.gap.store", 32'(store_count), 32'(EXP_STORES));
        clk_enable = 1'b1; data_write = 1'b0; active = 1'b1;
        instr_address = 32'h0000_0000;
        tick();
        tick(); tick();
        verdict("p6.pass", 1'b1, 1'b1, 1'b0, 3'd0, 32'd7);
        chk("p6.store", 32'(store_count), 32'(EXP_STORES));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
